rank_pipe_arbiter: RTL and testbench
====================================

Name: rank_pipe_arbiter

Overview:
Shares one rank pipe between NUM_PORTS independent enqueue requesters using round-robin arbitration. It registers the granted request in a single insertion stage and drives the rank pipe insert side, honouring its busy signal. It caps in-flight entries with a credit counter and drains rank pipe results into a registered valid/ready output stage. It sits between the per-port classifiers and the PIFO enqueue path.

Parameters:
NUM_PORTS, 4, number of requesters (≥2)
L2_NUM_PORTS, 2, log2(NUM_PORTS)
FLOW_ID_WIDTH, 16, flow ID width
FLOW_WEIGHT_WIDTH, 8, flow weight width
RANK_CODE_BITS, 2, rank op code width
NUM_RANK_OPS, 3, valid op codes are 0..NUM_RANK_OPS-1
RANK_WIDTH, 16, rank width
META_WIDTH, 16, metadata width
MAX_INFLIGHT, 32, maximum entries inserted into the rank pipe but not yet removed
CNT_WIDTH, 6, in-flight counter width (≥ clog2(MAX_INFLIGHT+1))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  grant enable; 0 = no new grants
req_valid  in  NUM_PORTS  per-port request
req_ready  out  NUM_PORTS  per-port accept (one-hot or zero)
req_rank_op  in  NUM_PORTS*RANK_CODE_BITS  packed op codes, port p at slice p
req_meta  in  NUM_PORTS*META_WIDTH  packed metadata
req_flowID  in  NUM_PORTS*FLOW_ID_WIDTH  packed flow IDs
req_flow_weight  in  NUM_PORTS*FLOW_WEIGHT_WIDTH  packed weights
pipe_busy  in  1  rank pipe cannot accept
pipe_insert  out  1  insert strobe
pipe_rank_op  out  RANK_CODE_BITS  stage op code
pipe_meta  out  META_WIDTH  stage metadata
pipe_flowID  out  FLOW_ID_WIDTH  stage flow ID
pipe_flow_weight  out  FLOW_WEIGHT_WIDTH  stage weight
pipe_valid_out  in  1  rank pipe result available
pipe_remove  out  1  remove strobe
pipe_rank_out  in  RANK_WIDTH  result rank
pipe_meta_out  in  META_WIDTH  result metadata
out_valid  out  1  output stage valid
out_ready  in  1  downstream accept
out_rank  out  RANK_WIDTH  registered rank
out_meta  out  META_WIDTH  registered metadata
inflight  out  CNT_WIDTH  current credit usage
drop_count  out  16  saturating count of invalid-op requests dropped

Behaviour:
- Reset (async, any cycle, including mid-transfer): stage empty, out_valid=0, out_rank/out_meta=0, inflight=0, drop_count=0, RR pointer=0 (port 0 highest priority). Entries already in the rank pipe are not tracked after reset; the rank pipe shares the same reset.
- Insert fire: pipe_insert = stage_valid & ~pipe_busy & (inflight < MAX_INFLIGHT). Combinational; pipe_* fields come from the stage registers.
- Stage free: free = ~stage_valid | pipe_insert.
- Grant: when en & free, select the first p with req_valid[p], scanning from ptr, ptr+1, … with wrap modulo NUM_PORTS. req_ready[p]=1 for that port only, combinationally in the same cycle. All other ports see 0.
- On grant, ptr <= p+1 mod NUM_PORTS. The pointer does not move when nothing is granted.
- Granted op < NUM_RANK_OPS: stage loads {op, meta, flowID, weight}; stage_valid=1 next cycle. Request-to-insert latency is 1 cycle minimum.
- Granted op ≥ NUM_RANK_OPS: request is consumed, stage is not loaded, and drop_count increments, saturating at 0xFFFF. Stage_valid then equals 0 if pipe_insert fired, else it holds.
- en=0: no grants; a loaded stage still drains.
- Credits: inflight +1 on pipe_insert, −1 on pipe_remove, unchanged on both. It never exceeds MAX_INFLIGHT and never underflows. pipe_remove without credit is a bench assertion failure.
- Output: pipe_remove = pipe_valid_out & (~out_valid | out_ready). On pipe_remove, out_rank/out_meta load and out_valid=1. On out_ready & out_valid without pipe_remove, out_valid=0. Both together give back-to-back throughput of 1/cycle.
- out_* hold stable while out_valid & ~out_ready.

Test Plan:
- Reset then single request port 2 (op=1, meta=0xABCD, flowID=7) -> req_ready[2]=1 same cycle; pipe_insert=1 next cycle with meta 0xABCD; inflight 0→1.
- All 4 ports valid continuously, pipe_busy=0 -> grants 0,1,2,3,0,1… one per cycle; pipe_insert every cycle after the first.
- pipe_busy held high 5 cycles with stage loaded -> req_ready all 0 and stage fields stable; insert fires the cycle busy drops, with a new grant in that same cycle.
- MAX_INFLIGHT=32 reached, no removals -> pipe_insert=0. One pipe_remove -> exactly one further insert, and inflight returns to 32.
- Port 1 op=3 -> req_ready[1]=1, no pipe_insert, drop_count=1. Repeat 65540 times -> drop_count=0xFFFF.
- pipe_valid_out=1 continuously, out_ready toggling 1,0,1 -> pipe_remove=1,0,1; no result lost or duplicated. Assert rst during stage_valid -> all outputs zero immediately.

Source files
------------

// File: rtl/rank_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rank_pipe_arbiter
//  Purpose  : Round-robin sharing of one rank pipe between NUM_PORTS enqueue
//             requesters, with credit-limited insertion and a registered
//             valid/ready result stage.
//  Revision : 1.0 - initial release
// ============================================================================
module rank_pipe_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int L2_NUM_PORTS      = 2,
    parameter int FLOW_ID_WIDTH     = 16,
    parameter int FLOW_WEIGHT_WIDTH = 8,
    parameter int RANK_CODE_BITS    = 2,
    parameter int NUM_RANK_OPS      = 3,
    parameter int RANK_WIDTH        = 16,
    parameter int META_WIDTH        = 16,
    parameter int MAX_INFLIGHT      = 32,
    parameter int CNT_WIDTH         = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    output logic [NUM_PORTS-1:0]                   req_ready,
    input  logic [NUM_PORTS*RANK_CODE_BITS-1:0]    req_rank_op,
    input  logic [NUM_PORTS*META_WIDTH-1:0]        req_meta,
    input  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0]     req_flowID,
    input  logic [NUM_PORTS*FLOW_WEIGHT_WIDTH-1:0] req_flow_weight,
    input  logic                                   pipe_busy,
    output logic                                   pipe_insert,
    output logic [RANK_CODE_BITS-1:0]              pipe_rank_op,
    output logic [META_WIDTH-1:0]                  pipe_meta,
    output logic [FLOW_ID_WIDTH-1:0]               pipe_flowID,
    output logic [FLOW_WEIGHT_WIDTH-1:0]           pipe_flow_weight,
    input  logic                                   pipe_valid_out,
    output logic                                   pipe_remove,
    input  logic [RANK_WIDTH-1:0]                  pipe_rank_out,
    input  logic [META_WIDTH-1:0]                  pipe_meta_out,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [RANK_WIDTH-1:0]                  out_rank,
    output logic [META_WIDTH-1:0]                  out_meta,
    output logic [CNT_WIDTH-1:0]                   inflight,
    output logic [15:0]                            drop_count
);

    localparam logic [CNT_WIDTH-1:0]      C_MAX_INFLIGHT = CNT_WIDTH'(MAX_INFLIGHT);
    localparam logic [RANK_CODE_BITS:0]   C_NUM_OPS      = (RANK_CODE_BITS+1)'(NUM_RANK_OPS);
    localparam logic [L2_NUM_PORTS:0]     C_NUM_PORTS    = (L2_NUM_PORTS+1)'(NUM_PORTS);

    logic                          stage_valid_q, stage_valid_d;
    logic [RANK_CODE_BITS-1:0]     stage_op_q, stage_op_d;
    logic [META_WIDTH-1:0]         stage_meta_q, stage_meta_d;
    logic [FLOW_ID_WIDTH-1:0]      stage_flow_q, stage_flow_d;
    logic [FLOW_WEIGHT_WIDTH-1:0]  stage_wt_q, stage_wt_d;
    logic [L2_NUM_PORTS-1:0]       ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]          inflight_q, inflight_d;
    logic [15:0]                   drop_q, drop_d;
    logic                          out_valid_q, out_valid_d;
    logic [RANK_WIDTH-1:0]         out_rank_q, out_rank_d;
    logic [META_WIDTH-1:0]         out_meta_q, out_meta_d;

    logic                          stage_free;
    logic                          grant_fire;
    logic                          op_ok;
    logic [L2_NUM_PORTS-1:0]       grant_idx;
    logic [L2_NUM_PORTS:0]         cand;
    logic [L2_NUM_PORTS:0]         next_ptr;
    logic [RANK_CODE_BITS-1:0]     sel_op;
    logic [META_WIDTH-1:0]         sel_meta;
    logic [FLOW_ID_WIDTH-1:0]      sel_flow;
    logic [FLOW_WEIGHT_WIDTH-1:0]  sel_wt;

    assign pipe_insert = stage_valid_q & ~pipe_busy & (inflight_q < C_MAX_INFLIGHT);
    assign stage_free  = ~stage_valid_q | pipe_insert;
    assign grant_fire  = en & stage_free & (|req_valid);
    assign op_ok       = {1'b0, sel_op} < C_NUM_OPS;
    assign pipe_remove = pipe_valid_out & (~out_valid_q | out_ready);

    // Scan offsets high-to-low so the smallest offset from ptr wins last.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            cand = {1'b0, ptr_q} + (L2_NUM_PORTS+1)'(j);
            if (cand >= C_NUM_PORTS) cand = cand - C_NUM_PORTS;
            if (req_valid[cand[L2_NUM_PORTS-1:0]]) grant_idx = cand[L2_NUM_PORTS-1:0];
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_meta  = '0;
        sel_flow  = '0;
        sel_wt    = '0;
        req_ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == L2_NUM_PORTS'(p)) begin
                sel_op       = req_rank_op[p*RANK_CODE_BITS +: RANK_CODE_BITS];
                sel_meta     = req_meta[p*META_WIDTH +: META_WIDTH];
                sel_flow     = req_flowID[p*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
                sel_wt       = req_flow_weight[p*FLOW_WEIGHT_WIDTH +: FLOW_WEIGHT_WIDTH];
                req_ready[p] = grant_fire;
            end
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_op_d    = stage_op_q;
        stage_meta_d  = stage_meta_q;
        stage_flow_d  = stage_flow_q;
        stage_wt_d    = stage_wt_q;
        ptr_d         = ptr_q;
        drop_d        = drop_q;
        inflight_d    = inflight_q;
        out_valid_d   = out_valid_q;
        out_rank_d    = out_rank_q;
        out_meta_d    = out_meta_q;
        next_ptr      = {1'b0, grant_idx} + (L2_NUM_PORTS+1)'(1);

        if (grant_fire) begin
            ptr_d = (next_ptr >= C_NUM_PORTS) ? '0 : next_ptr[L2_NUM_PORTS-1:0];
            if (op_ok) begin
                stage_valid_d = 1'b1;
                stage_op_d    = sel_op;
                stage_meta_d  = sel_meta;
                stage_flow_d  = sel_flow;
                stage_wt_d    = sel_wt;
            end else begin
                // Invalid op codes are consumed but never reach the rank pipe.
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                if (pipe_insert) stage_valid_d = 1'b0;
            end
        end else if (pipe_insert) begin
            stage_valid_d = 1'b0;
        end

        case ({pipe_insert, pipe_remove})
            2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CNT_WIDTH'(1);
            default: inflight_d = inflight_q;
        endcase

        if (pipe_remove) begin
            out_valid_d = 1'b1;
            out_rank_d  = pipe_rank_out;
            out_meta_d  = pipe_meta_out;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_op_q    <= '0;
            stage_meta_q  <= '0;
            stage_flow_q  <= '0;
            stage_wt_q    <= '0;
            ptr_q         <= '0;
            drop_q        <= '0;
            inflight_q    <= '0;
            out_valid_q   <= 1'b0;
            out_rank_q    <= '0;
            out_meta_q    <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_op_q    <= stage_op_d;
            stage_meta_q  <= stage_meta_d;
            stage_flow_q  <= stage_flow_d;
            stage_wt_q    <= stage_wt_d;
            ptr_q         <= ptr_d;
            drop_q        <= drop_d;
            inflight_q    <= inflight_d;
            out_valid_q   <= out_valid_d;
            out_rank_q    <= out_rank_d;
            out_meta_q    <= out_meta_d;
        end
    end

    assign pipe_rank_op     = stage_op_q;
    assign pipe_meta        = stage_meta_q;
    assign pipe_flowID      = stage_flow_q;
    assign pipe_flow_weight = stage_wt_q;
    assign out_valid        = out_valid_q;
    assign out_rank         = out_rank_q;
    assign out_meta         = out_meta_q;
    assign inflight         = inflight_q;
    assign drop_count       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_rank_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rank_pipe_arbiter
//  Purpose  : Self-checking bench for rank_pipe_arbiter against a behavioural
//             model of grants, stage occupancy, credits and the result stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rank_pipe_arbiter;
    localparam int N    = 4;
    localparam int MAXI = 32;

    logic        clk = 1'b0;
    logic        rst, en, pipe_busy, pipe_valid_out, out_ready;
    logic [3:0]  req_valid, req_ready;
    logic [7:0]  req_rank_op;
    logic [63:0] req_meta, req_flowID;
    logic [31:0] req_flow_weight;
    logic        pipe_insert, pipe_remove, out_valid;
    logic [1:0]  pipe_rank_op;
    logic [15:0] pipe_meta, pipe_flowID, pipe_rank_out, pipe_meta_out, out_rank, out_meta, drop_count;
    logic [7:0]  pipe_flow_weight;
    logic [5:0]  inflight;

    int checks = 0, failures = 0;
    int m_ptr, m_op, m_meta, m_flow, m_wt, m_infl, m_drop, m_orank, m_ometa, e_grant;
    bit m_sv, m_ov, e_insert, e_remove;
    logic [3:0] e_ready;

    always #5 clk = ~clk;

    rank_pipe_arbiter dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .req_rank_op(req_rank_op), .req_meta(req_meta), .req_flowID(req_flowID),
        .req_flow_weight(req_flow_weight), .pipe_busy(pipe_busy), .pipe_insert(pipe_insert),
        .pipe_rank_op(pipe_rank_op), .pipe_meta(pipe_meta), .pipe_flowID(pipe_flowID),
        .pipe_flow_weight(pipe_flow_weight), .pipe_valid_out(pipe_valid_out),
        .pipe_remove(pipe_remove), .pipe_rank_out(pipe_rank_out), .pipe_meta_out(pipe_meta_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_rank(out_rank), .out_meta(out_meta),
        .inflight(inflight), .drop_count(drop_count)
    );

    task automatic clear_inputs();
        en = 1'b1; req_valid = '0; req_rank_op = '0; req_meta = '0; req_flowID = '0;
        req_flow_weight = '0; pipe_busy = 1'b0; pipe_valid_out = 1'b0; out_ready = 1'b1;
        pipe_rank_out = '0; pipe_meta_out = '0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_sv = 0; m_op = 0; m_meta = 0; m_flow = 0; m_wt = 0;
        m_infl = 0; m_drop = 0; m_ov = 0; m_orank = 0; m_ometa = 0;
    endtask

    task automatic set_port(input int p, input int op, input int meta, input int flow, input int wt);
        req_rank_op[p*2 +: 2]      = 2'(op);
        req_meta[p*16 +: 16]       = 16'(meta);
        req_flowID[p*16 +: 16]     = 16'(flow);
        req_flow_weight[p*8 +: 8]  = 8'(wt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Expected combinational behaviour for the current inputs and model state.
    task automatic settle();
        int p;
        #1;
        e_insert = m_sv && !pipe_busy && (m_infl < MAXI);
        e_grant  = -1;
        if (en && (!m_sv || e_insert))
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (req_valid[p] && e_grant < 0) e_grant = p;
            end
        e_ready  = (e_grant >= 0) ? 4'(1 << e_grant) : 4'b0000;
        e_remove = pipe_valid_out && (!m_ov || out_ready);
    endtask

    task automatic advance();
        int op;
        assert (!(pipe_remove && inflight == 6'd0 && !pipe_insert)) else $error("pipe_remove without credit");
        m_infl = m_infl + int'(e_insert) - int'(e_remove);
        if (e_grant >= 0) begin
            m_ptr = (e_grant + 1) % N;
            op = int'(req_rank_op[e_grant*2 +: 2]);
            if (op < 3) begin
                m_sv = 1; m_op = op;
                m_meta = int'(req_meta[e_grant*16 +: 16]);
                m_flow = int'(req_flowID[e_grant*16 +: 16]);
                m_wt   = int'(req_flow_weight[e_grant*8 +: 8]);
            end else begin
                if (m_drop < 65535) m_drop++;
                if (e_insert) m_sv = 0;
            end
        end else if (e_insert) m_sv = 0;
        if (e_remove) begin
            m_ov = 1; m_orank = int'(pipe_rank_out); m_ometa = int'(pipe_meta_out);
        end else if (out_ready && m_ov) m_ov = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs();
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_rank !== 16'h0 || out_meta !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%0h/%0h exp=0/0", out_rank, out_meta); end
        checks++; if (inflight !== 6'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (pipe_insert !== 1'b0) begin failures++; $display("FAIL reset_insert got=%0h exp=0", pipe_insert); end
        @(negedge clk);
        rst = 1'b0; model_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_port(2, 1, 16'hABCD, 7, 8'h5A);
        req_valid = 4'b0100;
        settle();
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%0h exp=4", req_ready); end
        checks++; if (pipe_insert !== 1'b0) begin failures++; $display("FAIL single_insert0 got=%0h exp=0", pipe_insert); end
        advance();
        req_valid = 4'b0000;
        settle();
        checks++; if (pipe_insert !== 1'b1) begin failures++; $display("FAIL single_insert1 got=%0h exp=1", pipe_insert); end
        checks++; if (pipe_meta !== 16'hABCD || pipe_flowID !== 16'd7 || pipe_rank_op !== 2'd1 || pipe_flow_weight !== 8'h5A) begin
            failures++; $display("FAIL single_fields got=%0h/%0h/%0h/%0h exp=abcd/7/1/5a", pipe_meta, pipe_flowID, pipe_rank_op, pipe_flow_weight); end
        checks++; if (inflight !== 6'd0) begin failures++; $display("FAIL single_inflight0 got=%0d exp=0", inflight); end
        advance();
        settle();
        checks++; if (inflight !== 6'd1) begin failures++; $display("FAIL single_inflight1 got=%0d exp=1", inflight); end
        checks++; if (pipe_insert !== 1'b0) begin failures++; $display("FAIL single_insert2 got=%0h exp=0", pipe_insert); end
        advance();
    endtask

    task automatic test_round_robin();
        int prev_meta;
        int meta [4];
        do_reset();
        prev_meta = 0;
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            for (int p = 0; p < N; p++) begin
                meta[p] = int'($urandom_range(0, 65535));
                set_port(p, int'($urandom_range(0, 2)), meta[p], int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
            end
            settle();
            checks++; if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_grant k=%0d got=%0h exp=%0h", k, req_ready, 4'(1 << (k % 4))); end
            checks++; if (pipe_insert !== 1'(k > 0)) begin failures++; $display("FAIL rr_insert k=%0d got=%0h exp=%0h", k, pipe_insert, 1'(k > 0)); end
            if (k > 0) begin
                checks++; if (pipe_meta !== 16'(prev_meta)) begin failures++; $display("FAIL rr_meta k=%0d got=%0h exp=%0h", k, pipe_meta, 16'(prev_meta)); end
            end
            prev_meta = meta[k % 4];
            advance();
        end
    endtask

    task automatic test_busy();
        pipe_busy = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL busy_ready c=%0d got=%0h exp=0", c, req_ready); end
            checks++; if (pipe_insert !== 1'b0) begin failures++; $display("FAIL busy_insert c=%0d got=%0h exp=0", c, pipe_insert); end
            checks++; if (pipe_meta !== 16'(m_meta) || pipe_flowID !== 16'(m_flow)) begin
                failures++; $display("FAIL busy_hold c=%0d got=%0h/%0h exp=%0h/%0h", c, pipe_meta, pipe_flowID, 16'(m_meta), 16'(m_flow)); end
            advance();
        end
        pipe_busy = 1'b0;
        settle();
        checks++; if (pipe_insert !== 1'b1) begin failures++; $display("FAIL busy_release_insert got=%0h exp=1", pipe_insert); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL busy_release_grant got=%0h exp=1", req_ready); end
        advance();
        req_valid = 4'b0000;
        settle(); advance();
    endtask

    task automatic test_credit();
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 80; c++) begin
            for (int p = 0; p < N; p++)
                set_port(p, int'($urandom_range(0, 2)), int'($urandom_range(0, 65535)), p, p);
            settle();
            checks++; if (pipe_insert !== e_insert) begin failures++; $display("FAIL credit_fill_insert c=%0d got=%0h exp=%0h", c, pipe_insert, e_insert); end
            advance();
            if (m_infl >= MAXI && m_sv) break;
        end
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (pipe_insert !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL credit_cap c=%0d got=%0h/%0h exp=0/0", c, pipe_insert, req_ready); end
            checks++; if (inflight !== 6'd32) begin failures++; $display("FAIL credit_full c=%0d got=%0d exp=32", c, inflight); end
            advance();
        end
        pipe_valid_out = 1'b1; pipe_rank_out = 16'h1234; pipe_meta_out = 16'h4321;
        settle();
        checks++; if (pipe_remove !== 1'b1 || pipe_insert !== 1'b0) begin failures++; $display("FAIL credit_remove got=%0h/%0h exp=1/0", pipe_remove, pipe_insert); end
        advance();
        pipe_valid_out = 1'b0;
        settle();
        checks++; if (pipe_insert !== 1'b1 || inflight !== 6'd31) begin failures++; $display("FAIL credit_one_more got=%0h/%0d exp=1/31", pipe_insert, inflight); end
        advance();
        settle();
        checks++; if (pipe_insert !== 1'b0 || inflight !== 6'd32) begin failures++; $display("FAIL credit_refull got=%0h/%0d exp=0/32", pipe_insert, inflight); end
        advance();
    endtask

    task automatic test_drop();
        do_reset();
        set_port(1, 3, 16'h0BAD, 1, 1);
        req_valid = 4'b0010;
        settle();
        checks++; if (req_ready !== 4'b0010 || pipe_insert !== 1'b0) begin failures++; $display("FAIL drop_ready got=%0h/%0h exp=2/0", req_ready, pipe_insert); end
        advance();
        settle();
        checks++; if (drop_count !== 16'd1 || pipe_insert !== 1'b0) begin failures++; $display("FAIL drop_one got=%0d/%0h exp=1/0", drop_count, pipe_insert); end
        for (int i = 1; i < 65540; i++) begin
            advance(); settle();
        end
        checks++; if (drop_count !== 16'hFFFF) begin failures++; $display("FAIL drop_saturate got=%0h exp=ffff", drop_count); end
        checks++; if (drop_count !== 16'(m_drop)) begin failures++; $display("FAIL drop_model got=%0h exp=%0h", drop_count, 16'(m_drop)); end
        advance();
    endtask

    task automatic test_output();
        int sent[$];
        int got[$];
        bit seq [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_port(0, 0, c, c, c);
            req_valid = (c < 3) ? 4'b0001 : 4'b0000;
            settle(); advance();
        end
        pipe_valid_out = 1'b1;
        pipe_rank_out = 16'($urandom_range(0, 65535)); pipe_meta_out = 16'($urandom_range(0, 65535));
        for (int c = 0; c < 3; c++) begin
            out_ready = seq[c];
            settle();
            checks++; if (pipe_remove !== seq[c]) begin failures++; $display("FAIL out_remove c=%0d got=%0h exp=%0h", c, pipe_remove, seq[c]); end
            if (out_valid && out_ready) got.push_back(int'(out_rank));
            if (e_remove) sent.push_back(int'(pipe_rank_out));
            advance();
            if (sent.size() > 0 && m_orank == sent[$]) begin
                pipe_rank_out = 16'($urandom_range(0, 65535)); pipe_meta_out = 16'($urandom_range(0, 65535));
            end
        end
        pipe_valid_out = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            if (out_valid && out_ready) got.push_back(int'(out_rank));
            advance();
        end
        checks++; if (got.size() != 2 || sent.size() != 2) begin failures++; $display("FAIL out_count got=%0d exp=%0d", got.size(), sent.size()); end
        else begin
            checks++; if (got[0] != sent[0] || got[1] != sent[1]) begin failures++; $display("FAIL out_order got=%0h,%0h exp=%0h,%0h", got[0], got[1], sent[0], sent[1]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom_range(0, 15));
            for (int p = 0; p < N; p++)
                set_port(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
            pipe_busy      = ($urandom_range(0, 3) == 0);
            pipe_valid_out = ($urandom_range(0, 1) == 1) && (m_infl > 0);
            pipe_rank_out  = 16'($urandom_range(0, 65535));
            pipe_meta_out  = 16'($urandom_range(0, 65535));
            out_ready      = ($urandom_range(0, 2) != 0);
            settle();
            checks++; if (req_ready !== e_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, req_ready, e_ready); end
            checks++; if (pipe_insert !== e_insert || pipe_remove !== e_remove) begin failures++; $display("FAIL rnd_strobes c=%0d got=%0h/%0h exp=%0h/%0h", c, pipe_insert, pipe_remove, e_insert, e_remove); end
            checks++; if (inflight !== 6'(m_infl) || drop_count !== 16'(m_drop)) begin failures++; $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, inflight, drop_count, m_infl, m_drop); end
            checks++; if (out_valid !== m_ov) begin failures++; $display("FAIL rnd_out_valid c=%0d got=%0h exp=%0h", c, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_rank !== 16'(m_orank) || out_meta !== 16'(m_ometa)) begin failures++; $display("FAIL rnd_out_data c=%0d got=%0h/%0h exp=%0h/%0h", c, out_rank, out_meta, 16'(m_orank), 16'(m_ometa)); end
            end
            if (e_insert) begin
                checks++; if (pipe_rank_op !== 2'(m_op) || pipe_meta !== 16'(m_meta) || pipe_flowID !== 16'(m_flow) || pipe_flow_weight !== 8'(m_wt)) begin
                    failures++; $display("FAIL rnd_pipe_fields c=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", c, pipe_rank_op, pipe_meta, pipe_flowID, pipe_flow_weight, m_op, m_meta, m_flow, m_wt); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_port(3, 2, 16'h5555, 3, 3);
        req_valid = 4'b1000;
        settle(); advance();
        settle(); advance();
        pipe_valid_out = 1'b1; out_ready = 1'b0; pipe_rank_out = 16'h7777; pipe_meta_out = 16'h8888;
        settle(); advance();
        req_valid = 4'b0000; pipe_valid_out = 1'b0;
        settle();
        checks++; if (pipe_insert !== 1'b1 || out_valid !== 1'b1 || inflight !== 6'd1) begin
            failures++; $display("FAIL mid_pre got=%0h/%0h/%0d exp=1/1/1", pipe_insert, out_valid, inflight); end
        rst = 1'b1;
        #1;
        checks++; if (pipe_insert !== 1'b0 || out_valid !== 1'b0 || pipe_remove !== 1'b0) begin
            failures++; $display("FAIL mid_rst_strobes got=%0h/%0h/%0h exp=0/0/0", pipe_insert, out_valid, pipe_remove); end
        checks++; if (out_rank !== 16'h0 || out_meta !== 16'h0 || inflight !== 6'd0 || drop_count !== 16'd0) begin
            failures++; $display("FAIL mid_rst_values got=%0h/%0h/%0d/%0d exp=0/0/0/0", out_rank, out_meta, inflight, drop_count); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_credit();
        test_output();
        test_random();
        test_reset_mid();
        test_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
